// File: rtl/serial_dev.sv
// serial_dev: memory-mapped 8N1 UART responder for the CPU device range.
//
// Register map (16-bit, boolean TRUE = all ones, FALSE = zero):
//   0 TX_RDY  read : transmitter idle
//   1 TX_DAT  write: i_data[7:0] starts a frame if idle (dropped if busy); reads 0
//   2 RX_RDY  read : a received byte is waiting
//   3 RX_DAT  read : {8'h00, rx_buf}, clears the ready flag
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en, i_wr, i_addr    one-cycle access strobe, direction, register select
//   i_data / o_data       write data / registered read data (1-cycle latency)
//   i_rx / o_tx           serial input (asynchronous) / serial output, idle high
module serial_dev #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_SZ   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_wr,
    input  logic [1:0]         i_addr,
    input  logic [DATA_SZ-1:0] i_data,
    output logic [DATA_SZ-1:0] o_data,
    input  logic               i_rx,
    output logic               o_tx
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    // First RX sample lands in the middle of the start bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [DATA_SZ-1:0] TRUE_W  = '1;
    localparam logic [DATA_SZ-1:0] FALSE_W = '0;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Transmitter
    state_t             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               tx_q, tx_d;
    // Receiver
    logic               rx_meta_q, rx_sync_q;
    state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               rx_ferr_q, rx_ferr_d;
    logic [7:0]         rx_buf_q, rx_buf_d;
    logic               rx_ready_q, rx_ready_d;
    // Bus side
    logic [DATA_SZ-1:0] o_data_q, o_data_d;

    logic rd_acc, wr_tx, rd_rxdat, tx_done, tx_accept, rx_set;
    logic unused_data_bits;

    // Only the low byte of write data is ever used.
    assign unused_data_bits = ^i_data[DATA_SZ-1:8];

    assign rd_acc    = i_en & ~i_wr;
    assign wr_tx     = i_en & i_wr & (i_addr == 2'd1);
    assign rd_rxdat  = rd_acc & (i_addr == 2'd3);
    // The edge that ends the stop bit counts as idle, so a write there chains.
    assign tx_done   = (tx_state_q == ST_STOP) && (tx_cnt_q == '0);
    assign tx_accept = wr_tx && ((tx_state_q == ST_IDLE) || tx_done);

    // TX next state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            ST_IDLE: tx_d = 1'b1;
            ST_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = CNT_LAST;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = CNT_LAST;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = ST_IDLE;
                    tx_d       = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        if (tx_accept) begin
            tx_state_d = ST_START;
            tx_cnt_d   = CNT_LAST;
            tx_bit_d   = 3'd0;
            tx_shift_d = i_data[7:0];
            tx_d       = 1'b0;
        end
    end

    // RX next state
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        rx_buf_d   = rx_buf_q;
        rx_set     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_ferr_d = 1'b0;
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_cnt_d   = CNT_LAST;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = CNT_LAST;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_ferr_q) begin
                    // Framing error: hold (counter parked at 0) until the line is high.
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                        rx_ferr_d  = 1'b0;
                    end
                end else if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_buf_d   = rx_shift_q;
                        rx_set     = 1'b1;
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Ready flag: a completing byte wins over a same-cycle RX_DAT read.
    always_comb begin
        rx_ready_d = rx_ready_q;
        if (rd_rxdat) rx_ready_d = 1'b0;
        if (rx_set)   rx_ready_d = 1'b1;
    end

    // Read mux; o_data holds between reads.
    always_comb begin
        o_data_d = o_data_q;
        if (rd_acc) begin
            case (i_addr)
                2'd0:    o_data_d = (tx_state_q == ST_IDLE) ? TRUE_W : FALSE_W;
                2'd1:    o_data_d = FALSE_W;
                2'd2:    o_data_d = rx_ready_q ? TRUE_W : FALSE_W;
                default: o_data_d = DATA_SZ'(rx_buf_q);
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_ferr_q  <= 1'b0;
            rx_buf_q   <= 8'h00;
            rx_ready_q <= 1'b0;
            o_data_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_buf_q   <= rx_buf_d;
            rx_ready_q <= rx_ready_d;
            o_data_q   <= o_data_d;
        end
    end

    assign o_data = o_data_q;
    assign o_tx   = tx_q;

endmodule

// File: tb/tb_serial_dev.sv
// Bench for serial_dev with BAUD_DIV = 16 (CLK_FREQ=16, BAUD_RATE=1).
module tb_serial_dev;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        rx = 1'b1;
    logic        tx;

    serial_dev #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_SZ(16)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_en   (en),
        .i_wr   (wr),
        .i_addr (addr),
        .i_data (wdata),
        .o_data (rdata),
        .i_rx   (rx),
        .o_tx   (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] odata_model = 16'h0;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          w;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus access starting at a negedge; the expected o_data goes into the
    // scoreboard and is compared at the next negedge, after the sampling edge.
    task automatic access(input bit w, input logic [1:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input string name);
        sb_t e;
        en = 1'b1; wr = w; addr = a; wdata = d;
        e.exp  = w ? odata_model : exp_rd;
        e.name = name;
        odata_model = e.exp;
        sb_q.push_back(e);
        @(negedge clk);
        en = 1'b0; wr = 1'b0;
        e = sb_q.pop_front();
        check(e.name, rdata, e.exp);
        $display("txn %s addr=%0d wdata=%h o_data=%h", w ? "wr" : "rd", a, d, rdata);
    endtask

    // Called at the negedge just after the write edge; checks every cycle of
    // the 160-cycle frame and pokes the bus while busy. With chain set, a new
    // write is issued so that it lands on the edge that ends the stop bit.
    task automatic tx_frame(input logic [7:0] b, input bit chain, input logic [7:0] nb);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int c = 0; c < 160; c++) begin
            check($sformatf("tx_bit%0d_cyc%0d", c / 16, c), tx, frame[c / 16]);
            if (c == 20)
                access(1'b0, 2'd0, 16'h0, 16'h0000, "tx_rdy_busy");
            else if (c == 40)
                access(1'b1, 2'd1, 16'h00AA, 16'h0, "tx_wr_busy");
            else if (c == 159 && chain)
                access(1'b1, 2'd1, {8'h00, nb}, 16'h0, "tx_wr_at_done");
            else
                @(negedge clk);
        end
    endtask

    task automatic idle_tx(input int n);
        for (int i = 0; i < n; i++) begin
            check("tx_idle", tx, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd0, 16'h0000, 16'hFFFF, "vec_rd_tx_rdy"};
        vecs[1] = '{1'b1, 2'd2, 16'hBEEF, 16'h0000, "vec_wr_a2_hold"};
        vecs[2] = '{1'b0, 2'd2, 16'h0000, 16'h0000, "vec_rd_rx_rdy"};
        vecs[3] = '{1'b0, 2'd3, 16'h0000, 16'h0000, "vec_rd_rx_dat"};
        vecs[4] = '{1'b0, 2'd1, 16'h0000, 16'h0000, "vec_rd_tx_dat"};
        vecs[5] = '{1'b1, 2'd3, 16'h00FF, 16'h0000, "vec_wr_a3_hold"};
        vecs[6] = '{1'b0, 2'd0, 16'h0000, 16'hFFFF, "vec_rd_tx_rdy2"};
        vecs[7] = '{1'b0, 2'd2, 16'h0000, 16'h0000, "vec_rd_rx_rdy2"};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_odata", rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Register map table
        foreach (vecs[i]) begin
            access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].name);
            check("vec_tx_idle", tx, 1'b1);
        end

        // Single frame with a dropped busy write, then nothing follows
        access(1'b1, 2'd1, 16'h1255, 16'h0, "tx_wr_1255");
        tx_frame(8'h55, 1'b0, 8'h00);
        access(1'b0, 2'd0, 16'h0, 16'hFFFF, "tx_rdy_done");
        idle_tx(32);

        // Back-to-back frames: write accepted on the stop-bit completion edge
        access(1'b1, 2'd1, 16'h000F, 16'h0, "tx_wr_0f");
        tx_frame(8'h0F, 1'b1, 8'hF0);
        tx_frame(8'hF0, 1'b0, 8'h00);
        access(1'b0, 2'd0, 16'h0, 16'hFFFF, "tx_rdy_done2");
        idle_tx(32);

        // Receive 8'hC3
        send_rx(8'hC3, 1'b1);
        access(1'b0, 2'd2, 16'h0, 16'hFFFF, "rx_rdy_full");
        access(1'b0, 2'd3, 16'h0, 16'h00C3, "rx_dat_c3");
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rx_rdy_cleared");
        access(1'b0, 2'd3, 16'h0, 16'h00C3, "rx_dat_stale");
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rx_rdy_stale_noeffect");

        // Short glitch is not a start bit
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rx_glitch_rdy");

        // Framing error discards the byte
        send_rx(8'h3C, 1'b0);
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rx_ferr_rdy");
        access(1'b0, 2'd3, 16'h0, 16'h00C3, "rx_ferr_buf");

        // Recovery plus overrun: second byte overwrites, flag stays set
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        access(1'b0, 2'd2, 16'h0, 16'hFFFF, "rx_ovr_rdy");
        access(1'b0, 2'd3, 16'h0, 16'h0022, "rx_ovr_dat");
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rx_ovr_cleared");

        // Reset in the middle of a TX frame
        access(1'b1, 2'd1, 16'h0000, 16'h0, "tx_wr_00");
        repeat (50) @(negedge clk);
        check("tx_low_before_rst", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("tx_async_rst", tx, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        odata_model = 16'h0000;
        check("rst_tx_odata", rdata, 16'h0000);
        repeat (20) @(negedge clk);
        check("tx_aborted", tx, 1'b1);
        access(1'b0, 2'd0, 16'h0, 16'hFFFF, "rst_tx_rdy");
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rst_tx_rx_rdy");

        // Reset in the middle of an RX frame with a byte already waiting
        send_rx(8'h77, 1'b1);
        access(1'b0, 2'd2, 16'h0, 16'hFFFF, "rx_rdy_pre_rst");
        rx = 1'b0;
        repeat (40) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("rx_rst_tx", tx, 1'b1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        odata_model = 16'h0000;
        repeat (40) @(negedge clk);
        access(1'b0, 2'd2, 16'h0, 16'h0000, "rst_rx_rdy");
        access(1'b0, 2'd3, 16'h0, 16'h0000, "rst_rx_buf");
        access(1'b0, 2'd0, 16'h0, 16'hFFFF, "rst_rx_tx_rdy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
